// File: rtl/instr_fetch_unit.sv
// Purpose : instruction fetch front end; PC register, word-address drive, {pc, instr} fetch buffer.
// Latency : an instruction fetched in cycle N is presented on out_* in cycle N+1.
// Backpr. : a full buffer with no pop stalls fetch (pc and imem_addr hold); redirect flushes.
//
// Ports:
//   clk, rst_n                  rising-edge clock, synchronous active-low reset
//   imem_addr / imem_rdata      word index to memory, instruction returned same cycle
//   redirect_valid/redirect_pc  load new byte PC (bits [1:0] dropped), flush buffer
//   out_valid/out_ready         handshake to decode; out_instr/out_pc zero when idle
//   fifo_level                  current number of buffered instructions

// Generic synchronous FIFO with flush; head data is read combinationally.
// Latency : a pushed entry is visible at the head the following cycle.
// Backpr. : caller must not push when full (unless popping) nor pop when empty.
module fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage carries no reset: entries are only observed while counted in level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [LVL_W-1:0] fifo_level
);

  // PC is held as a word index: the byte offset is always zero, and the
  // 30-bit increment wraps exactly like a 32-bit pc+4.
  typedef struct packed {
    logic [29:0] pc_word;
    logic [31:0] instr;
  } fetch_ent_t;

  logic [29:0]      pc_word_q;
  logic             pop;
  logic             fetch;
  logic [LVL_W-1:0] level;
  fetch_ent_t       push_ent;
  fetch_ent_t       head_ent;
  logic             redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign pop   = out_valid && out_ready;
  // A full buffer can still accept a fetch when the head leaves this cycle.
  assign fetch = !redirect_valid && ((level < LVL_W'(FIFO_DEPTH)) || pop);

  assign push_ent.pc_word = pc_word_q;
  assign push_ent.instr   = imem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_word_q <= RESET_PC[31:2];
    end else if (redirect_valid) begin
      pc_word_q <= redirect_pc[31:2];
    end else if (fetch) begin
      pc_word_q <= pc_word_q + 30'd1;
    end
  end

  // A redirect flushes after any same-cycle pop: the consumer already owns
  // that head, and the flush clears whatever remains.
  fifo #(
    .W     ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fetch_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (fetch),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .level    (level)
  );

  assign imem_addr  = {2'b00, pc_word_q};
  assign fifo_level = level;
  assign out_valid  = (level != '0);
  assign out_instr  = out_valid ? head_ent.instr : 32'd0;
  assign out_pc     = out_valid ? {head_ent.pc_word, 2'b00} : 32'd0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Memory model: word i holds A000_0000 + i.
  assign imem_rdata = 32'hA000_0000 + imem_addr;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fifo_level     (fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every accepted handshake must match the next expected PC, and
  // its instruction must be the memory word at that PC.
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got pc %h expected no delivery", out_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", out_pc, e);
        chk("pop_instr", out_instr, 32'hA000_0000 + {2'b00, e[31:2]});
      end
    end
  end

  initial begin
    // Hand-computed delivery order for the cycle table below.
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
              32'h100, 32'h104, 32'h108,
              32'h18, 32'h1C, 32'h20,
              32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4,
              32'h0, 32'h4, 32'h8};

    for (int c = -2; c <= 37; c++) begin
      @(posedge clk);
      #1;
      rst_n          = (c >= 0) && (c != 30);
      out_ready      = !((c >= 5 && c <= 9) || c == 14 || (c >= 29 && c <= 31) || c >= 35);
      redirect_valid = (c == 14) || (c == 18) || (c == 22) || (c == 23);
      case (c)
        14:      redirect_pc = 32'h0000_0103;
        18:      redirect_pc = 32'h0000_001B;
        22:      redirect_pc = 32'h0000_0500;
        23:      redirect_pc = 32'hFFFF_FFF8;
        default: redirect_pc = 32'h0;
      endcase
      #1;
      case (c)
        -1: begin
          chk("rst_valid", {31'd0, out_valid}, 32'd0);
          chk("rst_pc", out_pc, 32'd0);
          chk("rst_instr", out_instr, 32'd0);
          chk("rst_level", {30'd0, fifo_level}, 32'd0);
          chk("rst_addr", imem_addr, 32'd0);
          mon_en = 1'b1;
        end
        0:  chk("release_valid", {31'd0, out_valid}, 32'd0);
        1: begin
          chk("first_valid", {31'd0, out_valid}, 32'd1);
          chk("first_pc", out_pc, 32'd0);
          chk("stream_level", {30'd0, fifo_level}, 32'd1);
        end
        7, 9: begin
          chk("stall_level", {30'd0, fifo_level}, 32'd2);
          chk("stall_addr", imem_addr, 32'd6);
          chk("stall_pc", out_pc, 32'h10);
          chk("stall_instr", out_instr, 32'hA000_0004);
        end
        15: begin
          chk("flush_level", {30'd0, fifo_level}, 32'd0);
          chk("flush_valid", {31'd0, out_valid}, 32'd0);
          chk("redir_addr", imem_addr, 32'h40);
        end
        16: begin
          chk("redir_valid", {31'd0, out_valid}, 32'd1);
          chk("redir_pc", out_pc, 32'h100);
        end
        23: chk("b2b_addr", imem_addr, 32'h140);
        24: begin
          chk("wrap_addr", imem_addr, 32'h3FFF_FFFE);
          chk("b2b_level", {30'd0, fifo_level}, 32'd0);
        end
        30: chk("full_level", {30'd0, fifo_level}, 32'd2);
        31: begin
          chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
          chk("mid_rst_pc", out_pc, 32'd0);
          chk("mid_rst_instr", out_instr, 32'd0);
          chk("mid_rst_level", {30'd0, fifo_level}, 32'd0);
          chk("mid_rst_addr", imem_addr, 32'd0);
        end
        32: chk("restart_pc", out_pc, 32'd0);
        default: ;
      endcase
    end

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL missing_pops: got %0d undelivered expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
